// File: rtl/ram_lanes_pkg.sv
// Shared definitions for the byte-lane RAM block.
//   - FSM state encoding (CLEAR sweep vs. normal IDLE service)
//   - byte width and a safe index-width helper
package ram_lanes_pkg;

    typedef logic [0:0] state_t;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    localparam int unsigned BYTE_W = 8;

    // Word-index width; never zero so a single-word RAM still gets a 1-bit address.
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_lanes_lane.sv
// ram_lane: one byte-wide, DEPTH_WORDS-deep memory with a registered read port.
// A single shared address serves either a write or a read each cycle, so the
// array maps onto a single-port block RAM.
// Ports:
//   clk      - clock
//   i_we     - write enable for this lane
//   i_re     - read enable (ignored when i_we is high)
//   i_addr   - word address
//   i_wdata  - write byte
//   o_rdata  - registered read byte, holds until the next read
module ram_lane
    import ram_lanes_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [AW-1:0]     i_addr,
    input  logic [BYTE_W-1:0] i_wdata,
    output logic [BYTE_W-1:0] o_rdata
);

    logic [BYTE_W-1:0] r_mem [DEPTH_WORDS];
    logic [BYTE_W-1:0] r_rdata;

    // Storage has no reset; the parent's clear sweep initialises it.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_lanes.sv
// ram_lanes: word-addressed RAM built from byte lanes, with per-lane active-low
// write mask, range checking, and a power-up clear sweep.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   req_valid    - request present
//   req_ready    - request can be accepted (low while clearing)
//   req_write    - 1 = write, 0 = read
//   address      - byte address; lane-select bits are ignored
//   data_in      - write data, lane n = bits [8n+7:8n]
//   write_mask   - active-low per-lane write enable
//   rsp_valid    - one-cycle response pulse, one cycle after accept
//   data_out     - read data; holds last read value between read responses
//   rsp_error    - response qualifier: address out of range
//   busy         - high while the clear sweep runs
module ram_lanes
    import ram_lanes_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_WIDTH  = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] write_mask,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    rsp_error,
    output logic                    busy
);

    localparam int unsigned LANES     = DATA_WIDTH / BYTE_W;
    localparam int unsigned LANE_BITS = $clog2(LANES);
    localparam int unsigned IDX_W     = ADDR_WIDTH - LANE_BITS;
    localparam int unsigned AW        = idx_bits(DEPTH_WORDS);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AW-1:0]       r_cnt;
    logic [AW-1:0]       w_cnt_nxt;
    logic                r_busy;
    logic                r_ready;
    logic                r_rsp_valid;
    logic                r_rsp_error;
    logic                r_rd_ok;
    logic [DATA_WIDTH-1:0] r_hold;

    logic [IDX_W-1:0]      w_index;
    logic                  w_in_range;
    logic                  w_accept;
    logic [LANES-1:0]      w_lane_we;
    logic                  w_lane_re;
    logic [AW-1:0]         w_lane_addr;
    logic [DATA_WIDTH-1:0] w_lane_wdata;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    // Request decode
    assign w_index    = address[ADDR_WIDTH-1:LANE_BITS];
    assign w_in_range = (64'(w_index) < 64'(DEPTH_WORDS));
    assign w_accept   = req_valid & r_ready & ~reset;

    if (LANE_BITS > 0) begin : g_lsb
        logic w_unused_lsb;
        assign w_unused_lsb = ^address[LANE_BITS-1:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt == ST_CLEAR);
            r_ready <= (w_state_nxt == ST_IDLE);
        end
    end

    // Next state and lane port control
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_lane_we    = '0;
        w_lane_re    = 1'b0;
        w_lane_addr  = r_cnt;
        w_lane_wdata = '0;
        case (r_state)
            ST_CLEAR: begin
                w_lane_we = {LANES{1'b1}};
                w_cnt_nxt = r_cnt + AW'(1);
                if (r_cnt == AW'(DEPTH_WORDS - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_IDLE: begin
                if (w_accept && w_in_range) begin
                    w_lane_addr = AW'(w_index);
                    if (req_write) begin
                        w_lane_we    = ~write_mask;
                        w_lane_wdata = data_in;
                    end else begin
                        w_lane_re = 1'b1;
                    end
                end
            end
        endcase
        // Nothing touches storage while reset is held.
        if (reset) begin
            w_lane_we = '0;
            w_lane_re = 1'b0;
        end
    end

    // Response registers; r_hold keeps the last read value between read responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rd_ok     <= 1'b0;
            r_hold      <= '0;
        end else begin
            r_rsp_valid <= w_accept;
            r_rsp_error <= w_accept & ~w_in_range;
            r_rd_ok     <= w_accept & ~req_write & w_in_range;
            // An out-of-range read presents zero next cycle, overriding any capture.
            if (w_accept && !req_write && !w_in_range) begin
                r_hold <= '0;
            end else if (r_rd_ok) begin
                r_hold <= w_ram_rdata;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        ram_lane #(
            .DEPTH_WORDS (DEPTH_WORDS),
            .AW          (AW)
        ) u_lane (
            .clk     (clk),
            .i_we    (w_lane_we[g]),
            .i_re    (w_lane_re),
            .i_addr  (w_lane_addr),
            .i_wdata (w_lane_wdata[g*BYTE_W +: BYTE_W]),
            .o_rdata (w_ram_rdata[g*BYTE_W +: BYTE_W])
        );
    end

    // In the cycle a read response is presented, the RAM output register is
    // the fresh data; otherwise the holding register keeps the last value.
    assign data_out  = r_rd_ok ? w_ram_rdata : r_hold;
    assign rsp_valid = r_rsp_valid;
    assign rsp_error = r_rsp_error;
    assign busy      = r_busy;
    assign req_ready = r_ready;

endmodule

// File: tb/tb_ram_lanes.sv
// Scoreboard bench for ram_lanes (32-bit words, 1024 words, 13-bit byte address).
module tb_ram_lanes;

    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int AWD   = 13;

    logic           clk;
    logic           reset;
    logic           req_valid;
    logic           req_ready;
    logic           req_write;
    logic [AWD-1:0] address;
    logic [DW-1:0]  data_in;
    logic [3:0]     write_mask;
    logic           rsp_valid;
    logic [DW-1:0]  data_out;
    logic           rsp_error;
    logic           busy;

    ram_lanes #(
        .DATA_WIDTH  (DW),
        .DEPTH_WORDS (DEPTH),
        .ADDR_WIDTH  (AWD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .address    (address),
        .data_in    (data_in),
        .write_mask (write_mask),
        .rsp_valid  (rsp_valid),
        .data_out   (data_out),
        .rsp_error  (rsp_error),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    // Reference model: plain word array, clear countdown, last-read value.
    exp_t          q[$];
    logic [DW-1:0] m_mem [DEPTH];
    int            m_clear_left = 0;
    logic [DW-1:0] m_last = '0;
    bit            m_started = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, pops one expectation per response.
    always @(negedge clk) begin
        if (m_started) begin
            exp_t e;
            check("busy", 32'(busy), 32'(m_clear_left > 0));
            check("req_ready", 32'(req_ready), 32'(m_clear_left == 0));
            check("rsp_valid", 32'(rsp_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                e = q.pop_front();
                if (rsp_valid === 1'b1) begin
                    check("rsp_error", 32'(rsp_error), 32'(e.err));
                    check("rsp_data", data_out, e.data);
                end
            end
            check("data_out_hold", data_out, m_last);
        end
    end

    // Drive one cycle, then apply the spec rules to the model at the edge.
    task automatic step(input logic rst, input logic v, input logic wr,
                        input logic [AWD-1:0] a, input logic [DW-1:0] d, input logic [3:0] m);
        int   idx;
        exp_t e;
        reset      = rst;
        req_valid  = v;
        req_write  = wr;
        address    = a;
        data_in    = d;
        write_mask = m;
        @(posedge clk);
        if (rst) begin
            m_started    = 1'b1;
            m_clear_left = DEPTH;
            m_last       = '0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else if (m_clear_left > 0) begin
            m_clear_left--;
        end else if (v) begin
            idx = int'(a) / 4;
            if (idx >= DEPTH) begin
                if (!wr) m_last = '0;
                e.err = 1'b1;
            end else begin
                if (wr) begin
                    for (int n = 0; n < 4; n++)
                        if (!m[n]) m_mem[idx][8*n +: 8] = d[8*n +: 8];
                end else begin
                    m_last = m_mem[idx];
                end
                e.err = 1'b0;
            end
            e.data = m_last;
            q.push_back(e);
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 4'hF);
    endtask

    task automatic rd(input logic [AWD-1:0] a);
        step(1'b0, 1'b1, 1'b0, a, 32'($urandom), 4'($urandom));
    endtask

    task automatic wr(input logic [AWD-1:0] a, input logic [DW-1:0] d, input logic [3:0] m);
        step(1'b0, 1'b1, 1'b1, a, d, m);
    endtask

    // Random request; half the time targets a few hot words to exercise
    // write-then-read of the same word, otherwise anywhere incl. out of range.
    task automatic rand_req(input logic rst);
        logic [AWD-1:0] a;
        if ($urandom_range(0, 1) == 0) a = AWD'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
        else                           a = AWD'($urandom_range(0, 13'h11FF));
        step(rst, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a,
             32'($urandom), 4'($urandom));
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        address = '0; data_in = '0; write_mask = 4'hF;

        // Reset, then the full clear sweep with idle inputs
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, '0, 4'hF);
        idle(DEPTH);
        idle(2);
        rd(13'h000);
        rd(13'hFFC);
        idle(1);

        // Full-word write, then masked write, each read back the next cycle
        wr(13'h010, 32'hDEADBEEF, 4'b0000);
        rd(13'h010);
        wr(13'h010, 32'h11223344, 4'b1010);
        rd(13'h010);
        idle(2);

        // Out of range, then word 0 unchanged; all-ones mask leaves data intact
        wr(13'h000, 32'hCAFEF00D, 4'b0000);
        wr(13'h1000, 32'h12345678, 4'b0000);
        rd(13'h1000);
        rd(13'h000);
        wr(13'h000, 32'hFFFFFFFF, 4'b1111);
        rd(13'h000);
        rd(13'h1FFC);
        idle(1);
        rd(13'h010);
        idle(3);

        // Random back-to-back traffic
        for (int i = 0; i < 2000; i++) rand_req(1'b0);
        idle(2);

        // Reset mid-clear at counter 500 with requests arriving during clear
        step(1'b1, 1'b0, 1'b0, '0, '0, 4'hF);
        for (int i = 0; i < 500; i++) rand_req(1'b0);
        rand_req(1'b1);
        for (int i = 0; i < DEPTH; i++) rand_req(1'b0);
        for (int i = 0; i < 8; i++) rd(AWD'(i * 4));
        rd(13'hFFC);

        // Reset in the middle of traffic, including a request on the reset edge
        for (int i = 0; i < 300; i++) rand_req(1'b0);
        wr(13'h008, 32'hA5A5A5A5, 4'b0000);
        rd(13'h008);
        step(1'b1, 1'b1, 1'b0, 13'h008, '0, 4'h0);
        for (int i = 0; i < DEPTH; i++) rand_req(1'b0);
        rd(13'h008);
        for (int i = 0; i < 300; i++) rand_req(1'b0);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
